// File: rtl/lc3_mem_arbiter_if.sv
// Request/response and memory-bus bundle between the LC3 pipeline and lc3_mem_arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface lc3_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              instrmem_rd;
    logic [ADDR_W-1:0] PC;
    logic [DATA_W-1:0] Instr_dout;
    logic              complete_instr;
    logic              Data_rd;
    logic              Data_wr;
    logic [ADDR_W-1:0] Data_addr;
    logic [DATA_W-1:0] Data_din;
    logic [DATA_W-1:0] Data_dout;
    logic              complete_data;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_err;

    modport slave (
        input  instrmem_rd, PC, Data_rd, Data_wr, Data_addr, Data_din,
               mem_rdata, mem_ready,
        output Instr_dout, complete_instr, Data_dout, complete_data,
               mem_en, mem_we, mem_addr, mem_wdata, mem_err
    );

    modport master (
        output instrmem_rd, PC, Data_rd, Data_wr, Data_addr, Data_din,
               mem_rdata, mem_ready,
        input  Instr_dout, complete_instr, Data_dout, complete_data,
               mem_en, mem_we, mem_addr, mem_wdata, mem_err
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Serialises LC3 fetch and load/store requests onto one single-ported memory;
// data requests win over fetch, each completion held until its request drops.
module lc3_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input logic                clock,
    input logic                reset,
    lc3_mem_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [TO_W-1:0]   cnt, cnt_n;
    logic              is_load, is_load_n;
    logic              mem_en_q, mem_en_n;
    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    logic              mem_err_q, mem_err_n;
    logic [DATA_W-1:0] instr_q, instr_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic              cmp_i_q, cmp_i_n;
    logic              cmp_d_q, cmp_d_n;
    logic              data_req;
    logic              finish;
    logic              timed_out;
    logic [DATA_W-1:0] result;

    assign data_req  = bus.Data_rd | bus.Data_wr;
    assign timed_out = !bus.mem_ready && (cnt == TO_LAST);
    assign finish    = bus.mem_ready || timed_out;
    assign result    = bus.mem_ready ? bus.mem_rdata : '0;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        is_load_n   = is_load;
        mem_en_n    = mem_en_q;
        mem_we_n    = mem_we_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        mem_err_n   = mem_err_q;
        instr_n     = instr_q;
        data_n      = data_q;
        cmp_i_n     = cmp_i_q;
        cmp_d_n     = cmp_d_q;

        case (state)
            IDLE: begin
                if (data_req) begin
                    state_n     = D_BUSY;
                    mem_en_n    = 1'b1;
                    mem_we_n    = bus.Data_wr;
                    mem_addr_n  = bus.Data_addr;
                    mem_wdata_n = bus.Data_din;
                    is_load_n   = bus.Data_rd & ~bus.Data_wr;
                    mem_err_n   = bus.Data_rd & bus.Data_wr;
                    cnt_n       = '0;
                end else if (bus.instrmem_rd) begin
                    state_n     = I_BUSY;
                    mem_en_n    = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = bus.PC;
                    mem_wdata_n = '0;
                    is_load_n   = 1'b0;
                    mem_err_n   = 1'b0;
                    cnt_n       = '0;
                end
            end

            // Both busy states share the ready/timeout handling; a timeout
            // completes like a read of zero with mem_err raised.
            I_BUSY, D_BUSY: begin
                if (!bus.mem_ready) begin
                    cnt_n = cnt + 1'b1;
                end
                if (finish) begin
                    mem_en_n = 1'b0;
                    if (timed_out) begin
                        mem_err_n = 1'b1;
                    end
                    if (state == I_BUSY) begin
                        instr_n = result;
                        cmp_i_n = 1'b1;
                        state_n = I_DONE;
                    end else begin
                        if (is_load) begin
                            data_n = result;
                        end
                        cmp_d_n = 1'b1;
                        state_n = D_DONE;
                    end
                end
            end

            I_DONE: begin
                if (!bus.instrmem_rd) begin
                    cmp_i_n = 1'b0;
                    state_n = IDLE;
                end
            end

            D_DONE: begin
                if (!data_req) begin
                    cmp_d_n = 1'b0;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            is_load     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_err_q   <= 1'b0;
            instr_q     <= '0;
            data_q      <= '0;
            cmp_i_q     <= 1'b0;
            cmp_d_q     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            is_load     <= is_load_n;
            mem_en_q    <= mem_en_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            mem_err_q   <= mem_err_n;
            instr_q     <= instr_n;
            data_q      <= data_n;
            cmp_i_q     <= cmp_i_n;
            cmp_d_q     <= cmp_d_n;
        end
    end

    assign bus.mem_en         = mem_en_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_err        = mem_err_q;
    assign bus.Instr_dout     = instr_q;
    assign bus.Data_dout      = data_q;
    assign bus.complete_instr = cmp_i_q;
    assign bus.complete_data  = cmp_d_q;
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: vector table with scoreboard plus
// hand-written reset, priority, early-drop and abort sequences.
module tb_lc3_mem_arbiter;
    localparam int TO = 4;

    logic clock;
    logic reset;
    int   tests;
    int   fails;

    lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    lc3_mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .TIMEOUT(TO),
        .TO_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        is_data;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] rdata;
        int          lat;      // edges with mem_en before ready; 0 = never ready
        logic [15:0] exp_instr;
        logic [15:0] exp_data;
        logic        exp_we;
        logic [15:0] exp_wdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] data;
        logic        err;
        int          cycles;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   cyc;
        logic done;
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clock);
        if (v.is_data) begin
            bus.Data_rd   = v.rd;
            bus.Data_wr   = v.wr;
            bus.Data_addr = v.addr;
            bus.Data_din  = v.din;
        end else begin
            bus.instrmem_rd = 1'b1;
            bus.PC          = v.addr;
        end
        sb.push_back('{v.exp_instr, v.exp_data, v.exp_err, (v.lat == 0) ? TO : v.lat});

        @(negedge clock);
        for (int i = 0; i < 8 && !bus.mem_en; i++) @(negedge clock);
        chk({p, " grant"}, 32'(bus.mem_en), 32'd1);
        chk({p, " addr"}, 32'(bus.mem_addr), 32'(v.addr));
        chk({p, " we"}, 32'(bus.mem_we), 32'(v.exp_we));
        chk({p, " wdata"}, 32'(bus.mem_wdata), 32'(v.exp_wdata));
        // addresses move while busy; the latched access must not follow them
        bus.PC        = ~v.addr;
        bus.Data_addr = ~v.addr;

        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 12) begin
            if (v.lat != 0 && cyc == v.lat - 1) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = v.rdata;
            end
            @(negedge clock);
            cyc++;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 16'hxxxx;
            done = v.is_data ? bus.complete_data : bus.complete_instr;
        end

        if (sb.size() == 0) begin
            chk({p, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({p, " cycles"}, 32'(cyc), 32'(e.cycles));
            chk({p, " instr"}, 32'(bus.Instr_dout), 32'(e.instr));
            chk({p, " data"}, 32'(bus.Data_dout), 32'(e.data));
            chk({p, " err"}, 32'(bus.mem_err), 32'(e.err));
        end
        chk({p, " en_drop"}, 32'(bus.mem_en), 32'd0);
        chk({p, " addr_held"}, 32'(bus.mem_addr), 32'(v.addr));

        @(negedge clock);
        chk({p, " cmp_hold"}, 32'(v.is_data ? bus.complete_data : bus.complete_instr), 32'd1);
        chk({p, " no_regrant"}, 32'(bus.mem_en), 32'd0);
        bus.instrmem_rd = 1'b0;
        bus.Data_rd     = 1'b0;
        bus.Data_wr     = 1'b0;
        @(negedge clock);
        chk({p, " cmp_drop"}, 32'(v.is_data ? bus.complete_data : bus.complete_instr), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        //            data rd   wr   addr      din       rdata     lat instr     data      we   wdata     err
        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1261, 3, 16'h1261, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h0A0A, 1, 16'h1261, 16'h0A0A, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h4002, 16'hBEEF, 16'hDEAD, 2, 16'h1261, 16'h0A0A, 1'b1, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0A0A, 1'b0, 16'h0000, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h4004, 16'h1234, 16'h9999, 1, 16'h0000, 16'h0A0A, 1'b1, 16'h1234, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h4006, 16'h0000, 16'hFFFF, 2, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 16'h3002, 16'h0000, 16'h5555, 1, 16'h5555, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h4008, 16'h0000, 16'h0000, 0, 16'h5555, 16'h0000, 1'b0, 16'h0000, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 16'h400A, 16'h00C3, 16'h7E7E, 3, 16'h5555, 16'h0000, 1'b1, 16'h00C3, 1'b0};

        bus.instrmem_rd = 1'b1;
        bus.Data_rd     = 1'b1;
        bus.Data_wr     = 1'b1;
        bus.PC          = 16'h1111;
        bus.Data_addr   = 16'h2222;
        bus.Data_din    = 16'h3333;
        bus.mem_rdata   = 16'h4444;
        bus.mem_ready   = 1'b0;
        reset           = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst cmp_i", 32'(bus.complete_instr), 32'd0);
        chk("rst cmp_d", 32'(bus.complete_data), 32'd0);
        chk("rst instr", 32'(bus.Instr_dout), 32'd0);
        chk("rst data", 32'(bus.Data_dout), 32'd0);
        chk("rst err", 32'(bus.mem_err), 32'd0);
        chk("rst addr", 32'(bus.mem_addr), 32'd0);
        chk("rst we", 32'(bus.mem_we), 32'd0);
        chk("rst wdata", 32'(bus.mem_wdata), 32'd0);
        bus.instrmem_rd = 1'b0;
        bus.Data_rd     = 1'b0;
        bus.Data_wr     = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // data wins a simultaneous request; fetch waits until data DONE exits
        @(negedge clock);
        bus.instrmem_rd = 1'b1;
        bus.PC          = 16'h3010;
        bus.Data_rd     = 1'b1;
        bus.Data_addr   = 16'h4000;
        @(negedge clock);
        chk("pri en", 32'(bus.mem_en), 32'd1);
        chk("pri addr", 32'(bus.mem_addr), 32'h4000);
        chk("pri we", 32'(bus.mem_we), 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h7777;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        chk("pri cmp_d", 32'(bus.complete_data), 32'd1);
        chk("pri data", 32'(bus.Data_dout), 32'h7777);
        @(negedge clock);
        chk("pri fetch_wait", 32'(bus.mem_en), 32'd0);
        chk("pri cmp_i_low", 32'(bus.complete_instr), 32'd0);
        bus.Data_rd = 1'b0;
        @(negedge clock);
        chk("pri cmp_d_drop", 32'(bus.complete_data), 32'd0);
        chk("pri idle_gap", 32'(bus.mem_en), 32'd0);
        @(negedge clock);
        chk("pri fetch_en", 32'(bus.mem_en), 32'd1);
        chk("pri fetch_addr", 32'(bus.mem_addr), 32'h3010);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h8888;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        chk("pri cmp_i", 32'(bus.complete_instr), 32'd1);
        chk("pri instr", 32'(bus.Instr_dout), 32'h8888);
        chk("pri data_hold", 32'(bus.Data_dout), 32'h7777);
        bus.instrmem_rd = 1'b0;
        @(negedge clock);
        chk("pri cmp_i_drop", 32'(bus.complete_instr), 32'd0);

        // request dropped while busy: one-cycle completion, no second grant
        @(negedge clock);
        bus.instrmem_rd = 1'b1;
        bus.PC          = 16'h3020;
        @(negedge clock);
        chk("drop en", 32'(bus.mem_en), 32'd1);
        bus.instrmem_rd = 1'b0;
        bus.mem_ready   = 1'b1;
        bus.mem_rdata   = 16'hABCD;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        chk("drop cmp", 32'(bus.complete_instr), 32'd1);
        chk("drop instr", 32'(bus.Instr_dout), 32'hABCD);
        @(negedge clock);
        chk("drop cmp_1cyc", 32'(bus.complete_instr), 32'd0);
        @(negedge clock);
        chk("drop no_regrant", 32'(bus.mem_en), 32'd0);

        // reset in the middle of a data access
        bus.Data_rd   = 1'b1;
        bus.Data_addr = 16'h4010;
        @(negedge clock);
        chk("abort en", 32'(bus.mem_en), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort en_drop", 32'(bus.mem_en), 32'd0);
        chk("abort cmp_d", 32'(bus.complete_data), 32'd0);
        chk("abort data", 32'(bus.Data_dout), 32'd0);
        bus.Data_rd = 1'b0;
        reset       = 1'b0;
        @(negedge clock);
        chk("abort idle", 32'(bus.mem_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
